// File: rtl/pipe_ctrl_pkg.sv
// Shared types and widths for the pipeline stall/flush sequencer.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        RELEASE  = 2'd2,
        ERROR    = 2'd3
    } pipe_state_e;

    localparam int WDOG_W = 8;
    localparam int CNT_W  = 32;

endpackage

// File: rtl/wdog_timer.sv
// Saturating cycle counter guarding the SRAM wait; expired_o flags the last allowed wait cycle.
module wdog_timer
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    localparam logic [WDOG_W-1:0] LIMIT   = WDOG_W'(TIMEOUT_CYCLES - 1);
    localparam logic [WDOG_W-1:0] SAT_MAX = '1;

    logic [WDOG_W-1:0] count_q;
    logic [WDOG_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (enable_i && (count_q != SAT_MAX)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Expiry is only meaningful while the wait is actually being timed.
    assign expired_o = enable_i && (count_q == LIMIT);

endmodule

// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline with SRAM handshake and watchdog.
// Optional perf counters are built only when PIPE_PERF_CNT_EN is defined.
module pipeline_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              hazard_detected,
    input  logic              branch_taken,
    input  logic              mem_req,
    input  logic              sram_ready,
    output logic              sram_req,
    output logic              freeze_pc,
    output logic              freeze_if_id,
    output logic              freeze_id_exe,
    output logic              freeze_exe_mem,
    output logic              flush_if_id,
    output logic              flush_id_exe,
    output logic              wb_bubble,
    output logic              mem_timeout,
    output logic [CNT_W-1:0]  stall_cycles,
    output logic [CNT_W-1:0]  flush_count
);

    pipe_state_e state_q;
    pipe_state_e state_d;
    logic        wdog_expired;
    logic        wdog_clear;
    logic        wdog_enable;

    logic sram_req_d, freeze_pc_d, freeze_if_id_d, freeze_id_exe_d, freeze_exe_mem_d;
    logic flush_if_id_d, flush_id_exe_d, wb_bubble_d, mem_timeout_d;

    assign wdog_clear  = (state_q == RUN) && mem_req;
    assign wdog_enable = (state_q == MEM_WAIT);

    wdog_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_wdog (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear_i   (wdog_clear),
        .enable_i  (wdog_enable),
        .expired_o (wdog_expired)
    );

    always_comb begin
        state_d          = state_q;
        sram_req_d       = 1'b0;
        freeze_pc_d      = 1'b0;
        freeze_if_id_d   = 1'b0;
        freeze_id_exe_d  = 1'b0;
        freeze_exe_mem_d = 1'b0;
        flush_if_id_d    = 1'b0;
        flush_id_exe_d   = 1'b0;
        wb_bubble_d      = 1'b0;
        mem_timeout_d    = 1'b0;
        case (state_q)
            RUN, RELEASE: begin
                // In RELEASE mem_req still belongs to the access that just completed.
                if ((state_q == RUN) && mem_req) begin
                    sram_req_d       = 1'b1;
                    freeze_pc_d      = 1'b1;
                    freeze_if_id_d   = 1'b1;
                    freeze_id_exe_d  = 1'b1;
                    freeze_exe_mem_d = 1'b1;
                    wb_bubble_d      = 1'b1;
                    state_d          = MEM_WAIT;
                end else begin
                    if (branch_taken) begin
                        flush_if_id_d  = 1'b1;
                        flush_id_exe_d = 1'b1;
                    end else if (hazard_detected) begin
                        freeze_pc_d    = 1'b1;
                        freeze_if_id_d = 1'b1;
                        flush_id_exe_d = 1'b1;
                    end
                    state_d = RUN;
                end
            end
            MEM_WAIT: begin
                sram_req_d       = 1'b1;
                freeze_pc_d      = 1'b1;
                freeze_if_id_d   = 1'b1;
                freeze_id_exe_d  = 1'b1;
                freeze_exe_mem_d = 1'b1;
                wb_bubble_d      = 1'b1;
                if (sram_ready) begin
                    state_d = RELEASE;
                end else if (wdog_expired) begin
                    state_d = ERROR;
                end
            end
            default: begin
                freeze_pc_d      = 1'b1;
                freeze_if_id_d   = 1'b1;
                freeze_id_exe_d  = 1'b1;
                freeze_exe_mem_d = 1'b1;
                wb_bubble_d      = 1'b1;
                mem_timeout_d    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Gating with rst_n makes every control drop the moment reset asserts, even mid-access.
    assign sram_req       = sram_req_d       & rst_n;
    assign freeze_pc      = freeze_pc_d      & rst_n;
    assign freeze_if_id   = freeze_if_id_d   & rst_n;
    assign freeze_id_exe  = freeze_id_exe_d  & rst_n;
    assign freeze_exe_mem = freeze_exe_mem_d & rst_n;
    assign flush_if_id    = flush_if_id_d    & rst_n;
    assign flush_id_exe   = flush_id_exe_d   & rst_n;
    assign wb_bubble      = wb_bubble_d      & rst_n;
    assign mem_timeout    = mem_timeout_d    & rst_n;

`ifdef PIPE_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cycles_q;
    logic [CNT_W-1:0] flush_count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles_q <= '0;
            flush_count_q  <= '0;
        end else begin
            if (freeze_pc_d) begin
                stall_cycles_q <= stall_cycles_q + 1'b1;
            end
            if (flush_if_id_d) begin
                flush_count_q <= flush_count_q + 1'b1;
            end
        end
    end

    assign stall_cycles = stall_cycles_q;
    assign flush_count  = flush_count_q;
`else
    assign stall_cycles = '0;
    assign flush_count  = '0;
`endif

endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Central stall/flush sequencer for the 5-stage pipeline. It merges three inputs into one set of per-stage freeze and flush controls: the hazard unit's `hazard_detected`, the EXE-stage `branch_taken`, and the MEM-stage request to the multi-cycle SRAM. It also drives the SRAM request/ready handshake and guards it with a watchdog. It sits beside the hazard unit and feeds the PC register and the IF/ID, ID/EXE, EXE/MEM and MEM/WB pipeline registers.

## Interface
- `TIMEOUT_CYCLES`, default 255: maximum number of MEM_WAIT cycles before the block declares a timeout. Legal range is 1..255.
- `clk`  in  1  the single clock. All state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `hazard_detected`  in  1  RAW hazard flag from the hazard unit.
- `branch_taken`  in  1  branch resolved as taken in EXE.
- `mem_req`  in  1  the instruction in MEM performs a load or store.
- `sram_ready`  in  1  one-cycle pulse from the SRAM controller when the access completes.
- `sram_req`  out  1  SRAM access request.
- `freeze_pc`, `freeze_if_id`, `freeze_id_exe`, `freeze_exe_mem`  out  1 each  hold the corresponding register.
- `flush_if_id`  out  1  load a NOP into IF/ID.
- `flush_id_exe`  out  1  load a bubble into ID/EXE.
- `wb_bubble`  out  1  the MEM/WB register captures an invalid entry.
- `mem_timeout`  out  1  sticky error flag.
- `stall_cycles`  out  32  perf counter (see Configuration).
- `flush_count`  out  32  perf counter (see Configuration).

## Operation
- States: RUN, MEM_WAIT, RELEASE, ERROR. Reset state is RUN.
- All outputs are combinational from the current state and inputs, except the counters.
- **RUN** actions are evaluated in priority order:
  - Memory stall (`mem_req` = 1): assert all four freezes, `wb_bubble` and `sram_req`. Next state is MEM_WAIT. The watchdog clears.
  - Branch (`branch_taken` = 1, no memory stall): assert `flush_if_id` and `flush_id_exe`. No freezes. Hazard is ignored, because the ID instruction is wrong-path.
  - Hazard (`hazard_detected` = 1, neither of the above): assert `freeze_pc`, `freeze_if_id` and `flush_id_exe`.
  - Otherwise all outputs are 0.
- **MEM_WAIT**:
  - All four freezes, `wb_bubble` and `sram_req` are held at 1. Branch and hazard inputs are ignored.
  - The watchdog increments each cycle.
  - If `sram_ready` = 1, next state is RELEASE. This check has priority over the timeout check.
  - Otherwise, if the watchdog equals `TIMEOUT_CYCLES` − 1, next state is ERROR.
- **RELEASE** lasts one cycle:
  - No freezes and `sram_req` = 0. The completed instruction advances to WB.
  - `mem_req` is ignored, because it still reflects the completed instruction.
  - Branch and hazard are handled as in RUN. A branch that was held frozen in EXE flushes here.
  - Next state is RUN.
- **ERROR**:
  - All freezes = 1, `wb_bubble` = 1, `sram_req` = 0, `mem_timeout` = 1.
  - The only exit is reset.
- The watchdog is 8 bits wide and saturates. It is only meaningful in MEM_WAIT.
- `sram_ready` is ignored outside MEM_WAIT.

## Timing
- Reset (asynchronous, `rst_n` low):
  - State returns to RUN.
  - Watchdog, `mem_timeout` and the counters clear to 0.
  - All outputs read 0 while in reset.
  - Reset asserted mid-wait aborts the access: `sram_req` drops immediately.
- Stall length:
  - A memory access of N wait cycles costs N+1 frozen cycles: the RUN entry cycle plus N cycles in MEM_WAIT.
  - After those, one RELEASE cycle follows.
  - `sram_ready` arriving in the first MEM_WAIT cycle gives the minimum stall of 2 cycles.
- A hazard stall lasts exactly as long as `hazard_detected` stays high. There is no internal latency.
- A branch flush lasts 1 cycle per taken branch, in the cycle the EXE instruction advances.
- `sram_req` rises in the same cycle `mem_req` is seen in RUN. It stays high until the edge at which `sram_ready` is sampled.

## Configuration
- `PIPE_PERF_CNT_EN` defined:
  - `stall_cycles` increments on every cycle with `freeze_pc` = 1.
  - `flush_count` increments on every cycle with `flush_if_id` = 1.
  - Both are 32-bit and wrap at 2^32.
- `PIPE_PERF_CNT_EN` undefined: both ports are tied to 0 and no counter flops are built. Port list is unchanged.

## Structure
- `pipe_ctrl_pkg` holds:
  - the state enum (RUN, MEM_WAIT, RELEASE, ERROR) in a 2-bit encoding;
  - `WDOG_W` = 8;
  - the counter width constant, 32.
- One sub-module, `wdog_timer`:
  - ports: clear, enable, `TIMEOUT_CYCLES`;
  - output: `expired`.
- The FSM, output decode and perf counters stay in `pipeline_ctrl`.

## Test plan
- Load with `sram_ready` 3 cycles after entering MEM_WAIT:
  - freezes and `sram_req` are high for 4 cycles;
  - RELEASE follows with all controls at 0;
  - `stall_cycles` = 4.
- `hazard_detected` high for 2 cycles in RUN:
  - `freeze_pc`, `freeze_if_id` and `flush_id_exe` are high for exactly 2 cycles;
  - `sram_req` stays 0.
- `branch_taken` and `hazard_detected` together: `flush_if_id` = `flush_id_exe` = 1, no freeze, `flush_count` += 1.
- `mem_req` and `branch_taken` together, `sram_ready` after 1 wait cycle:
  - no flush during the stall;
  - flush occurs in the RELEASE cycle.
- `TIMEOUT_CYCLES` = 4 and `sram_ready` never arrives:
  - ERROR is entered after 4 MEM_WAIT cycles;
  - `mem_timeout` = 1 and is sticky;
  - `rst_n` pulse returns to RUN with all outputs 0.
- `rst_n` asserted in the 2nd MEM_WAIT cycle: `sram_req` and freezes drop asynchronously, and the counters read 0.
